// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the digit-serial adder.
//   - FSM state encoding (enum plus legacy-compatible localparam constants)
//   - helpers deriving the number of digit steps and the step-counter width
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   function automatic int calc_steps(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-step configuration still needs a 1-bit counter.
   function automatic int calc_cnt_w(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder built from full-adder cells.
// Ports:
//   a, b  [DIGIT-1:0]  operand digits
//   cin                carry into bit 0
//   sum   [DIGIT-1:0]  digit sum
//   cout               carry out of the top bit
//   ctop               carry into the top bit (for signed overflow)
module digit_adder
   import serial_adder_pkg::*;
#(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             ctop
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[DIGIT];
   assign ctop = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial WIDTH-bit adder, DIGIT bits per clock, with
// valid/ready handshakes on operand and result sides.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port (a - b).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, cin[, sub])
//   out_valid / out_ready result handshake (sum, carry, overflow)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one digit per cycle, sum shifted in from the MSB end
// DONE  | result valid, waiting for out_ready
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int STEPS = calc_steps(WIDTH, DIGIT);
   localparam int CNT_W = calc_cnt_w(STEPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             c_reg;
   logic [CNT_W-1:0] cnt;
   logic [DIGIT-1:0] d_sum;
   logic             d_cout;
   logic             d_ctop;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
   // a - b == a + ~b + 1; cin is not used when subtracting.
   always_comb begin
      b_load = sub ? ~b : b;
      c_load = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_load = b;
      c_load = cin;
   end
`endif

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .cin  (c_reg),
      .sum  (d_sum),
      .cout (d_cout),
      .ctop (d_ctop)
   );

   // Each new digit enters at the MSB; after STEPS shifts the LSB digit lands at bit 0.
   if (DIGIT == WIDTH) begin : g_sum_full
      assign sum_next = d_sum;
   end else begin : g_sum_shift
      assign sum_next = {d_sum, sum[WIDTH-1:DIGIT]};
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         c_reg    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  c_reg <= c_load;
                  cnt   <= CNT_LAST;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               c_reg <= d_cout;
               sum   <= sum_next;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  carry    <= d_cout;
                  overflow <= d_cout ^ d_ctop;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
